// File: rtl/conv2_maxpool_relu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv2_maxpool_relu : 2x2 stride-2 max pooling with optional ReLU            |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module conv2_maxpool_relu #(
   parameter int DW   = 14,
   parameter int IN_W = 8,
   parameter int IN_H = 8,
   parameter int RELU = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic signed [DW-1:0] data_in,
   output logic signed [DW-1:0] data_out,
   output logic                 valid_out,
   output logic                 frame_done
);

   localparam int CW = $clog2(IN_W);
   localparam int RW = $clog2(IN_H);
   localparam int BN = IN_W / 2;
   localparam int BW = (BN > 1) ? $clog2(BN) : 1;

   logic        [CW-1:0] col;
   logic        [RW-1:0] row;
   logic signed [DW-1:0] hold_reg;
   logic signed [DW-1:0] line_buf [BN];

   logic        [BW-1:0] buf_idx;
   logic signed [DW-1:0] pair;
   logic signed [DW-1:0] win_max;
   logic signed [DW-1:0] pooled;
   logic                 last_col;
   logic                 last_row;

   always_comb begin
      buf_idx  = BW'(col >> 1);
      last_col = (col == CW'(IN_W - 1));
      last_row = (row == RW'(IN_H - 1));
      pair     = (data_in > hold_reg) ? data_in : hold_reg;
      win_max  = (line_buf[buf_idx] > pair) ? line_buf[buf_idx] : pair;
      pooled   = win_max;
      if (RELU != 0 && win_max < 0) begin
         pooled = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         hold_reg   <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in) begin
            if (!col[0]) begin
               hold_reg <= data_in;
            end else if (row[0]) begin
               data_out   <= pooled;
               valid_out  <= 1'b1;
               frame_done <= last_col && last_row;
            end
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Even rows park their horizontal pair maxima until the odd row arrives.
   always_ff @(posedge clk) begin
      if (!rst && valid_in && col[0] && !row[0]) begin
         line_buf[buf_idx] <= pair;
      end
   end

endmodule
`default_nettype wire

// File: doc/conv2_maxpool_relu.md
Name: conv2_maxpool_relu

Overview:
Consumer end of the conv2 channel-calc output stream. It accepts the 14-bit signed convolution samples one at a time under a valid strobe, in raster order. It performs 2x2 stride-2 max pooling with optional ReLU and emits one pooled sample per 2x2 window to the flatten/FC stage. One instance serves one conv2 output channel; the output frame is IN_W/2 x IN_H/2.

Parameters:
DW, 14, sample width (signed, two's complement), input and output
IN_W, 8, conv output row length in samples (even, >=2)
IN_H, 8, conv output rows per frame (even, >=2)
RELU, 1, 1 = clamp negative pooled results to 0; 0 = pass signed max

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
valid_in  input  1  data_in holds a new conv sample this cycle
data_in  input  DW  signed conv sample, raster order (col fastest)
data_out  output  DW  signed pooled sample
valid_out  output  1  one-cycle pulse; data_out is a new pooled sample
frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame

Behaviour:
- Reset (rst=1 at a clk edge):
  - col=0, row=0, hold_reg=0.
  - data_out=0, valid_out=0, frame_done=0.
  - Line buffer contents are don't-care; they are always written on an even row before being read.
  - rst has priority over a simultaneous valid_in; that sample is dropped.
- State: col counter 0..IN_W-1, row counter 0..IN_H-1, hold_reg (DW), line_buf[IN_W/2] (DW each).
- All comparisons are signed DW-bit. Ties give the equal value.
- On each edge with valid_in=1 (and rst=0):
  - Even col: hold_reg <= data_in.
  - Odd col: pair = max(hold_reg, data_in).
    - Even row: line_buf[col>>1] <= pair. No output.
    - Odd row: m = max(line_buf[col>>1], pair). If RELU=1 and m<0, m=0. data_out <= m; valid_out <= 1.
  - Counters: col increments. At IN_W-1, col wraps to 0 and row increments. At row IN_H-1, row also wraps to 0, with no extra idle cycle needed between frames.
  - frame_done <= 1 when the sample is row=IN_H-1, col=IN_W-1.
- Any edge without an output event: valid_out <= 0, frame_done <= 0. data_out holds its last value.
- Latency: valid_out/data_out are visible the cycle after the edge that accepted the window's last sample (odd row, odd col).
- Throughput: accepts one sample per cycle. Arbitrary idle gaps (valid_in=0) are allowed anywhere; all state holds through a gap. The upstream toggling-valid pattern (valid every other cycle) is supported directly.
- No backpressure: the consumer must accept valid_out whenever it is asserted.
- Output count: exactly (IN_W/2)*(IN_H/2) valid_out pulses per frame; 16 at default parameters.
- Reset mid-frame: the partial frame is discarded. The next accepted sample is treated as row 0, col 0, and no stale output is produced.

Test Plan:
1. Reset, then 64 consecutive samples, value = row*8+col. Required: 16 valid_out pulses with data_out = 9,11,13,15, 25,27,29,31, 41,43,45,47, 57,59,61,63. frame_done is high only with the value-63 pulse, and each pulse follows its sample by one cycle.
2. A frame of all -5: with RELU=1, 16 outputs of 0; with RELU=0, 16 outputs of -5 (0x3FFB).
3. Signed extremes, RELU=0:
   - Window {-8192, 8191 / -1, 0} gives 8191 (0x1FFF).
   - Window of all -8192 gives 0x2000.
   - Window {-1, -2 / -3, -4} gives -1 (0x3FFF).
4. The test-1 data with valid_in asserted every other cycle, plus random 0-5 cycle gaps. Required: an identical output sequence, with each valid_out one cycle after the odd-row/odd-col sample.
5. 20 samples of test-1 data, then rst for 1 cycle, then a full test-1 frame. Required: exactly 16 outputs matching test 1, no output during or right after reset, and a rst edge that coincides with valid_in accepts nothing.
6. 128 back-to-back samples (two test-1 frames). Required: 32 outputs, the second 16 identical to the first, and frame_done pulsing exactly twice (one cycle after samples 64 and 128).
